// File: rtl/rtcl_p3s7_hs_cnv_axi4s_mp.sv
// PYTHON300 multi-pixel raw stream to black/image AXI4-Stream converter.
// Optional status counters are enabled with RTCL_CNV_AXI4S_STATUS_CNT_EN.
module rtcl_p3s7_hs_cnv_axi4s_mp #(
    parameter int PIXELS    = 1,
    parameter int RAW_BITS  = 10,
    parameter int X_BITS    = 10,
    parameter int Y_BITS    = 10,
    parameter int USER_BITS = 2
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [X_BITS-1:0]            param_black_width,
    input  logic [Y_BITS-1:0]            param_black_height,
    input  logic [X_BITS-1:0]            param_image_width,
    input  logic [Y_BITS-1:0]            param_image_height,
    input  logic                         s_first,
    input  logic                         s_last,
    input  logic [PIXELS*RAW_BITS-1:0]   s_data,
    input  logic                         s_valid,
    output logic [PIXELS*RAW_BITS-1:0]   m_black_tdata,
    output logic [USER_BITS-1:0]         m_black_tuser,
    output logic                         m_black_tlast,
    output logic                         m_black_tvalid,
    input  logic                         m_black_tready,
    output logic [PIXELS*RAW_BITS-1:0]   m_image_tdata,
    output logic [USER_BITS-1:0]         m_image_tuser,
    output logic                         m_image_tlast,
    output logic                         m_image_tvalid,
    input  logic                         m_image_tready,
`ifdef RTCL_CNV_AXI4S_STATUS_CNT_EN
    output logic [31:0]                  frame_count,
    output logic [31:0]                  short_count,
    output logic [31:0]                  overflow_count,
`endif
    output logic                         frame_done,
    output logic                         err_short,
    output logic                         err_overflow
);

    // Each master is valid/ready: a beat transfers on an edge where tvalid && tready;
    // tvalid, tdata, tuser and tlast hold while tvalid && !tready.
    typedef enum logic [1:0] {IDLE, BLACK, IMAGE} state_t;

    state_t              state_q, state_d, region;
    logic [X_BITS-1:0]   x_q, x_d, cx, w, bw_q, iw_q, bw_e, iw_e;
    logic [Y_BITS-1:0]   y_q, y_d, cy, h, bh_q, ih_q, bh_e, ih_e;
    logic                accepted, start, last_x, last_y;
    logic                load_b, load_i, done_d, short_d, ovf_d;
    logic [USER_BITS-1:0] user_d;

    assign accepted = s_valid && (s_data != '0);
    assign start    = accepted && s_first;

    // A start beat uses the live parameters; every later beat uses the latched copy.
    always_comb begin
        bw_e = start ? param_black_width  : bw_q;
        bh_e = start ? param_black_height : bh_q;
        iw_e = start ? param_image_width  : iw_q;
        ih_e = start ? param_image_height : ih_q;
        if (bw_e == '0) bw_e = X_BITS'(1);
        if (iw_e == '0) iw_e = X_BITS'(1);
        if (ih_e == '0) ih_e = Y_BITS'(1);
    end

    always_comb begin
        region  = IDLE;
        cx      = x_q;
        cy      = y_q;
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        done_d  = 1'b0;
        short_d = 1'b0;
        ovf_d   = 1'b0;
        load_b  = 1'b0;
        load_i  = 1'b0;
        if (start) begin
            region = (bh_e != '0) ? BLACK : IMAGE;
            cx     = '0;
            cy     = '0;
        end else if (accepted && state_q != IDLE) begin
            region = state_q;
        end
        w       = (region == BLACK) ? bw_e : iw_e;
        h       = (region == BLACK) ? bh_e : ih_e;
        last_x  = (cx == w - X_BITS'(1));
        last_y  = (cy == h - Y_BITS'(1));
        user_d    = '0;
        user_d[0] = (cx == '0) && (cy == '0);
        user_d[1] = last_x && last_y;

        if (region != IDLE) begin
            if (region == BLACK) begin
                load_b = !(m_black_tvalid && !m_black_tready);
                ovf_d  = !load_b;
            end else begin
                load_i = !(m_image_tvalid && !m_image_tready);
                ovf_d  = !load_i;
            end
            // Counters advance even when the beat is dropped, keeping line geometry intact.
            if (region == IMAGE && last_x && last_y) begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
                done_d  = 1'b1;
            end else if (s_last) begin
                state_d = IDLE;
                x_d     = '0;
                y_d     = '0;
                short_d = 1'b1;
            end else if (last_x && last_y) begin
                state_d = IMAGE;
                x_d     = '0;
                y_d     = '0;
            end else if (last_x) begin
                state_d = region;
                x_d     = '0;
                y_d     = cy + Y_BITS'(1);
            end else begin
                state_d = region;
                x_d     = cx + X_BITS'(1);
                y_d     = cy;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            bw_q    <= '0;
            bh_q    <= '0;
            iw_q    <= '0;
            ih_q    <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (start) begin
                bw_q <= bw_e;
                bh_q <= bh_e;
                iw_q <= iw_e;
                ih_q <= ih_e;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_black_tvalid <= 1'b0;
            m_black_tdata  <= '0;
            m_black_tuser  <= '0;
            m_black_tlast  <= 1'b0;
            m_image_tvalid <= 1'b0;
            m_image_tdata  <= '0;
            m_image_tuser  <= '0;
            m_image_tlast  <= 1'b0;
            frame_done     <= 1'b0;
            err_short      <= 1'b0;
            err_overflow   <= 1'b0;
        end else begin
            frame_done   <= done_d;
            err_short    <= short_d;
            err_overflow <= ovf_d;
            if (load_b) begin
                m_black_tvalid <= 1'b1;
                m_black_tdata  <= s_data;
                m_black_tuser  <= user_d;
                m_black_tlast  <= last_x;
            end else if (m_black_tready) begin
                m_black_tvalid <= 1'b0;
            end
            if (load_i) begin
                m_image_tvalid <= 1'b1;
                m_image_tdata  <= s_data;
                m_image_tuser  <= user_d;
                m_image_tlast  <= last_x;
            end else if (m_image_tready) begin
                m_image_tvalid <= 1'b0;
            end
        end
    end

`ifdef RTCL_CNV_AXI4S_STATUS_CNT_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            frame_count    <= '0;
            short_count    <= '0;
            overflow_count <= '0;
        end else begin
            if (frame_done)   frame_count    <= frame_count + 32'd1;
            if (err_short)    short_count    <= short_count + 32'd1;
            if (err_overflow) overflow_count <= overflow_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rtcl_p3s7_hs_cnv_axi4s_mp.sv
// Scoreboard bench for rtcl_p3s7_hs_cnv_axi4s_mp with two pixels per beat.
module tb_rtcl_p3s7_hs_cnv_axi4s_mp;
    localparam int PIXELS = 2, RAW_BITS = 10, X_BITS = 10, Y_BITS = 10, USER_BITS = 2;
    localparam int DW = PIXELS * RAW_BITS;
    localparam int W  = DW + USER_BITS + 1;

    logic aclk = 1'b0, aresetn = 1'b0;
    logic [X_BITS-1:0] param_black_width = '0, param_image_width = '0;
    logic [Y_BITS-1:0] param_black_height = '0, param_image_height = '0;
    logic s_first = 1'b0, s_last = 1'b0, s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic [DW-1:0] m_black_tdata, m_image_tdata;
    logic [USER_BITS-1:0] m_black_tuser, m_image_tuser;
    logic m_black_tlast, m_black_tvalid, m_image_tlast, m_image_tvalid;
    logic m_black_tready = 1'b1, m_image_tready = 1'b1;
    logic frame_done, err_short, err_overflow;
`ifdef RTCL_CNV_AXI4S_STATUS_CNT_EN
    logic [31:0] frame_count, short_count, overflow_count;
`endif

    rtcl_p3s7_hs_cnv_axi4s_mp #(.PIXELS(PIXELS), .RAW_BITS(RAW_BITS), .X_BITS(X_BITS),
        .Y_BITS(Y_BITS), .USER_BITS(USER_BITS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .param_black_width(param_black_width), .param_black_height(param_black_height),
        .param_image_width(param_image_width), .param_image_height(param_image_height),
        .s_first(s_first), .s_last(s_last), .s_data(s_data), .s_valid(s_valid),
        .m_black_tdata(m_black_tdata), .m_black_tuser(m_black_tuser),
        .m_black_tlast(m_black_tlast), .m_black_tvalid(m_black_tvalid),
        .m_black_tready(m_black_tready),
        .m_image_tdata(m_image_tdata), .m_image_tuser(m_image_tuser),
        .m_image_tlast(m_image_tlast), .m_image_tvalid(m_image_tvalid),
        .m_image_tready(m_image_tready),
`ifdef RTCL_CNV_AXI4S_STATUS_CNT_EN
        .frame_count(frame_count), .short_count(short_count),
        .overflow_count(overflow_count),
`endif
        .frame_done(frame_done), .err_short(err_short), .err_overflow(err_overflow)
    );

    always #5 aclk = ~aclk;

    logic [W-1:0] exp_black_q[$];
    logic [W-1:0] exp_image_q[$];
    int n_cmp = 0, n_err = 0;
    int done_cnt = 0, short_cnt = 0, ovf_cnt = 0;
    int exp_done = 0, exp_short = 0, exp_ovf = 0;
    logic stall_prev = 1'b0;
    logic [W-1:0] stall_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: compares each transfer against the scoreboard and counts pulses.
    always @(negedge aclk) begin
        if (aresetn) begin
            if (m_black_tvalid && m_black_tready) begin
                if (exp_black_q.size() == 0) check("black_extra", 64'(m_black_tdata), 64'hDEAD);
                else check("black_beat", 64'({m_black_tlast, m_black_tuser, m_black_tdata}),
                           64'(exp_black_q.pop_front()));
            end
            if (m_image_tvalid && m_image_tready) begin
                if (exp_image_q.size() == 0) check("image_extra", 64'(m_image_tdata), 64'hDEAD);
                else check("image_beat", 64'({m_image_tlast, m_image_tuser, m_image_tdata}),
                           64'(exp_image_q.pop_front()));
            end
            if (m_image_tvalid && !m_image_tready) begin
                if (stall_prev) check("image_hold", 64'({m_image_tlast, m_image_tuser, m_image_tdata}),
                                      64'(stall_word));
                stall_prev = 1'b1;
                stall_word = {m_image_tlast, m_image_tuser, m_image_tdata};
            end else begin
                stall_prev = 1'b0;
            end
            if (frame_done)   done_cnt++;
            if (err_short)    short_cnt++;
            if (err_overflow) ovf_cnt++;
        end
    end

    function automatic logic [DW-1:0] rand_pix();
        logic [DW-1:0] d;
        for (int l = 0; l < PIXELS; l++) d[l*RAW_BITS +: RAW_BITS] = RAW_BITS'($urandom_range(1, 1023));
        return d;
    endfunction

    // Drives one sensor frame of n beats; beat k of the frame maps to the black region
    // first (row-major), then the image region. Beats past the frame end are ignored.
    task automatic drive_frame(input int bw, input int bh, input int iw, input int ih,
                               input int n, input bit gap, input int stall_k, input bit chg);
        int ebw, eiw, eih, nb, total, x, y, wd, ht, j;
        bit blk, drop, lx;
        logic [DW-1:0] d;
        ebw = (bw == 0) ? 1 : bw;
        eiw = (iw == 0) ? 1 : iw;
        eih = (ih == 0) ? 1 : ih;
        nb = (bh == 0) ? 0 : ebw * bh;
        total = nb + eiw * eih;
        param_black_width = X_BITS'(bw);
        param_black_height = Y_BITS'(bh);
        param_image_width = X_BITS'(iw);
        param_image_height = Y_BITS'(ih);
        for (int k = 0; k < n; k++) begin
            if (chg && k == 5) begin
                param_black_width = 2;
                param_black_height = 1;
                param_image_width = 2;
                param_image_height = 2;
            end
            d = rand_pix();
            drop = (stall_k >= 0) && (k > stall_k) && (k <= stall_k + 2);
            if (k < total && !drop) begin
                blk = (k < nb);
                j = blk ? k : k - nb;
                wd = blk ? ebw : eiw;
                ht = blk ? bh : eih;
                x = j % wd;
                y = j / wd;
                lx = (x == wd - 1);
                if (blk) exp_black_q.push_back({lx, lx && (y == ht - 1), (x == 0 && y == 0), d});
                else     exp_image_q.push_back({lx, lx && (y == ht - 1), (x == 0 && y == 0), d});
            end
            s_valid = 1'b1;
            s_first = (k == 0);
            s_last = (k == n - 1);
            s_data = d;
            m_image_tready = !drop;
            @(posedge aclk); #1;
            if (gap) begin
                s_data = '0;
                s_first = 1'($urandom_range(0, 1));
                s_last = 1'($urandom_range(0, 1));
                m_image_tready = 1'b1;
                @(posedge aclk); #1;
            end
        end
        s_valid = 1'b0;
        s_first = 1'b0;
        s_last = 1'b0;
        s_data = '0;
        m_image_tready = 1'b1;
        if (n >= total) exp_done++;
        else exp_short++;
        if (stall_k >= 0) exp_ovf += 2;
        repeat (6) @(posedge aclk);
        #1;
        check("black_left", 64'(exp_black_q.size()), 64'd0);
        check("image_left", 64'(exp_image_q.size()), 64'd0);
        check("frame_done_cnt", 64'(done_cnt), 64'(exp_done));
        check("err_short_cnt", 64'(short_cnt), 64'(exp_short));
        check("err_overflow_cnt", 64'(ovf_cnt), 64'(exp_ovf));
    endtask

    initial begin
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_black_tvalid", 64'(m_black_tvalid), 64'd0);
        check("rst_image_tvalid", 64'(m_image_tvalid), 64'd0);
        check("rst_pulses", 64'({frame_done, err_short, err_overflow}), 64'd0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(posedge aclk); #1;

        drive_frame(4, 2, 8, 3, 32, 1'b0, -1, 1'b0);   // baseline
        drive_frame(4, 2, 8, 3, 32, 1'b1, -1, 1'b0);   // zero beats interleaved
        drive_frame(4, 0, 4, 2, 8, 1'b0, -1, 1'b0);    // no black region
        drive_frame(4, 2, 8, 3, 19, 1'b0, -1, 1'b0);   // s_last on image beat 10
        drive_frame(4, 2, 8, 3, 32, 1'b0, -1, 1'b0);
        drive_frame(4, 2, 8, 3, 32, 1'b0, 10, 1'b0);   // image backpressure at x=2
        drive_frame(4, 2, 8, 3, 32, 1'b0, -1, 1'b1);   // live params change mid-frame
        drive_frame(4, 2, 2, 2, 12, 1'b0, -1, 1'b0);
        drive_frame(2, 1, 0, 0, 3, 1'b0, -1, 1'b0);    // zero image geometry acts as 1x1
        drive_frame(3, 1, 5, 2, 16, 1'b0, -1, 1'b0);   // extra beats after completion

        // Reset with a beat held in the image register.
        param_black_height = 0;
        param_image_width = 4;
        param_image_height = 2;
        m_image_tready = 1'b0;
        s_valid = 1'b1;
        s_first = 1'b1;
        s_data = rand_pix();
        @(posedge aclk); #1;
        s_valid = 1'b0;
        s_first = 1'b0;
        check("pre_rst_image_tvalid", 64'(m_image_tvalid), 64'd1);
        aresetn = 1'b0;
        @(posedge aclk); #1;
        check("mid_rst_image_tvalid", 64'(m_image_tvalid), 64'd0);
        check("mid_rst_black_tvalid", 64'(m_black_tvalid), 64'd0);
        aresetn = 1'b1;
        m_image_tready = 1'b1;
        done_cnt = 0; short_cnt = 0; ovf_cnt = 0;
        exp_done = 0; exp_short = 0; exp_ovf = 0;
        // Stray beats without s_first are dropped while idle.
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1;
            s_data = rand_pix();
            @(posedge aclk); #1;
        end
        s_valid = 1'b0;
        drive_frame(4, 2, 8, 3, 32, 1'b0, -1, 1'b0);
        drive_frame(4, 2, 8, 3, 20, 1'b0, 9, 1'b0);
`ifdef RTCL_CNV_AXI4S_STATUS_CNT_EN
        check("frame_count", 64'(frame_count), 64'(exp_done));
        check("short_count", 64'(short_count), 64'(exp_short));
        check("overflow_count", 64'(overflow_count), 64'(exp_ovf));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rtcl_p3s7_hs_cnv_axi4s_mp.md
Name: rtcl_p3s7_hs_cnv_axi4s_mp

Overview:
Multi-pixel successor of the PYTHON300 raw-to-AXI4-Stream converter in the Spartan-7/KV260 high-speed path. It accepts the deserialised sensor stream, PIXELS lanes per beat, framed by first/last markers. It discards all-zero sync/idle beats and splits each frame into a black-reference region and an image region, each emitted on its own AXI4-Stream master with frame-start/frame-end tuser and line tlast. Unlike the single-pixel version, it latches geometry per frame, supports tready backpressure with drop detection, and reports frame-done and short-frame status.

Parameters:
PIXELS, 1, pixels per beat; lanes packed LSB-first in s_data/tdata
RAW_BITS, 10, bits per pixel
X_BITS, 10, width of beat counters and width parameters (units: beats)
Y_BITS, 10, width of line counters and height parameters
USER_BITS, 2, tuser width; bit0 = frame start, bit1 = frame end, upper bits 0

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
param_black_width  in  X_BITS  black beats per line
param_black_height  in  Y_BITS  black lines; 0 = no black region
param_image_width  in  X_BITS  image beats per line
param_image_height  in  Y_BITS  image lines
s_first  in  1  first beat of sensor frame
s_last  in  1  last beat of sensor frame
s_data  in  PIXELS*RAW_BITS  raw lanes
s_valid  in  1  input beat valid; no backpressure to source
m_black_tdata/tuser/tlast/tvalid  out  PIXELS*RAW_BITS/USER_BITS/1/1  black stream
m_black_tready  in  1  black stream ready
m_image_tdata/tuser/tlast/tvalid  out  PIXELS*RAW_BITS/USER_BITS/1/1  image stream
m_image_tready  in  1  image stream ready
frame_done  out  1  one-cycle pulse on last image beat
err_short  out  1  one-cycle pulse on premature s_last
err_overflow  out  1  one-cycle pulse when a beat is dropped

Behaviour:
- Reset: all tvalid, frame_done, err_short and err_overflow = 0; state IDLE; counters 0.
- Beat accepted = s_valid and at least one lane nonzero. All-zero beats are ignored and do not advance counters.
- Parameters are latched when an accepted beat with s_first arrives. Live values are ignored mid-frame. Width or height of 0 for the image region is treated as 1.
- States: IDLE, BLACK, IMAGE.
  - IDLE + accepted s_first: go to BLACK if latched black_height != 0, else IMAGE. That beat is x=0, y=0. Accepted beats without s_first are dropped silently.
  - BLACK: x increments per accepted beat. At x = width-1, x clears and y increments. After the last beat of line height-1: go to IMAGE with x=y=0.
  - IMAGE: same counting. After the last beat of the last line: frame_done pulse, go to IDLE. Further beats are ignored until the next s_first.
- Accepted s_first in BLACK/IMAGE: restart the frame at x=y=0 with newly latched parameters. No error is raised.
- s_last accepted in BLACK/IMAGE before frame completion: the beat is emitted normally, then the state returns to IDLE. err_short pulses once. The output tuser[1] is not forced.
- s_last coinciding with the final image beat: normal completion; err_short = 0.
- Output: one register stage per master; tdata equals the accepted s_data; latency is 1 cycle from accepted beat to tvalid.
  - tlast = (x == width-1).
  - tuser[0] = (x==0 && y==0) of the region.
  - tuser[1] = tlast && (y == height-1).
- Handshake: tvalid holds until tready. If a new beat targets a master whose register is full and not being taken that cycle, the new beat is dropped and err_overflow pulses. Counters still advance, so geometry is preserved. tdata/tuser/tlast are stable while tvalid && !tready.
- Only the master for the current region receives beats; the other master's tvalid is unaffected.
- Reset mid-frame: outputs cleared immediately; state returns to IDLE.

Optional Feature:
RTCL_CNV_AXI4S_STATUS_CNT_EN.
- Defined: adds three 32-bit wrapping outputs, frame_count, short_count and overflow_count. Each increments on frame_done, err_short and err_overflow respectively. All are cleared by reset.
- Undefined: these ports and their counters do not exist; pulse outputs are unchanged.

Test Plan:
- PIXELS=2, black 4x2, image 8x3, frame of 32 nonzero beats with s_first on beat 0 and s_last on beat 31, tready=1 -> black gets 8 beats (tlast on beats 3 and 7, tuser=1 on the first, tuser=2 on the last), image gets 24 beats, one frame_done, no errors.
- Same frame with all-zero beats inserted between every beat -> identical outputs; zero beats never appear on either master.
- param_black_height=0, image 4x2 -> black tvalid never asserts; image gets 8 beats; tuser[0] on the first beat.
- s_last on image beat 10 of 24 -> beat 10 emitted, err_short pulses once, no frame_done, next s_first frame is fully correct.
- m_image_tready held 0 for 3 cycles mid-line -> first held beat stays stable, next 2 beats dropped with 2 err_overflow pulses, tlast still lands on x=7.
- Parameters changed to image 2x2 mid-frame -> current frame keeps 8x3 geometry; the next frame uses 2x2.
